// File: rtl/drive_cmd_ctrl.sv
// drive_cmd_ctrl: synchronises and debounces the forward/backward/stop
// buttons, turns debounced presses into fixed-length drive commands and
// enforces a dead-time after every motion before any new motion.
module drive_cmd_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_CYCLES      = 100000000,
  parameter int DEAD_CYCLES     = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_fwd,
  input  logic       btn_bwd,
  input  logic       btn_stop,
  output logic       forward,
  output logic       backward,
  output logic       busy,
  output logic [1:0] state
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW  = $clog2(RUN_CYCLES + 1);
  localparam int DW  = $clog2(DEAD_CYCLES + 1);

  // Counters hold "cycles remaining minus one", so zero marks the last cycle.
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  RUN_LAST  = RW'(RUN_CYCLES - 1);
  localparam logic [DW-1:0]  DEAD_LAST = DW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_FWD = 2'd1,
    RUN_BWD = 2'd2,
    DEAD    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_FWD  = 2'd1,
    PEND_BWD  = 2'd2
  } pend_t;

  // Button bit order everywhere: [0]=fwd, [1]=bwd, [2]=stop.
  logic [2:0]     sync1_q, sync1_d;
  logic [2:0]     sync2_q, sync2_d;
  logic [2:0]     level_q, level_d;
  logic [2:0]     press_q, press_d;
  logic [DBW-1:0] db_cnt_q [3];
  logic [DBW-1:0] db_cnt_d [3];

  state_t         state_q, state_d;
  pend_t          pend_q, pend_d;
  logic [RW-1:0]  run_cnt_q, run_cnt_d;
  logic [DW-1:0]  dead_cnt_q, dead_cnt_d;
  logic           forward_q, forward_d;
  logic           backward_q, backward_d;
  logic           busy_q, busy_d;

  logic           ev_stop, ev_fwd, ev_bwd;

  // Two-flop synchroniser chain for the raw buttons.
  always_comb begin
    sync1_d = {btn_stop, btn_bwd, btn_fwd};
    sync2_d = sync1_q;
  end

  // Per-button debounce: level flips after DEBOUNCE_CYCLES differing samples; 0->1 flips raise a press pulse.
  always_comb begin
    level_d = level_q;
    press_d = 3'b000;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i]  = ~level_q[i];
          press_d[i]  = ~level_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Event priority: stop wins; simultaneous fwd+bwd without stop cancel out.
  always_comb begin
    ev_stop = press_q[2];
    ev_fwd  = press_q[0] & ~press_q[1] & ~press_q[2];
    ev_bwd  = press_q[1] & ~press_q[0] & ~press_q[2];
  end

  // Drive FSM next-state, run/dead timers, pending direction and registered output values.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    run_cnt_d  = run_cnt_q;
    dead_cnt_d = dead_cnt_q;
    case (state_q)
      IDLE: begin
        if (ev_fwd) begin
          state_d   = RUN_FWD;
          run_cnt_d = RUN_LAST;
        end else if (ev_bwd) begin
          state_d   = RUN_BWD;
          run_cnt_d = RUN_LAST;
        end else begin
          state_d = IDLE;
        end
      end
      RUN_FWD, RUN_BWD: begin
        if (ev_stop) begin
          state_d    = DEAD;
          dead_cnt_d = DEAD_LAST;
          pend_d     = PEND_NONE;
        end else if ((state_q == RUN_FWD && ev_bwd) || (state_q == RUN_BWD && ev_fwd)) begin
          state_d    = DEAD;
          dead_cnt_d = DEAD_LAST;
          pend_d     = ev_fwd ? PEND_FWD : PEND_BWD;
        end else if (ev_fwd || ev_bwd) begin
          // Same-direction press extends the run by a full period.
          run_cnt_d = RUN_LAST;
        end else if (run_cnt_q == '0) begin
          state_d    = DEAD;
          dead_cnt_d = DEAD_LAST;
          pend_d     = PEND_NONE;
        end else begin
          run_cnt_d = run_cnt_q - RW'(1);
        end
      end
      DEAD: begin
        // Presses only retarget the pending move; the dead-time is never restarted.
        if (ev_stop) begin
          pend_d = PEND_NONE;
        end else if (ev_fwd) begin
          pend_d = PEND_FWD;
        end else if (ev_bwd) begin
          pend_d = PEND_BWD;
        end else begin
          pend_d = pend_q;
        end
        if (dead_cnt_q == '0) begin
          case (pend_d)
            PEND_FWD: begin
              state_d   = RUN_FWD;
              run_cnt_d = RUN_LAST;
            end
            PEND_BWD: begin
              state_d   = RUN_BWD;
              run_cnt_d = RUN_LAST;
            end
            default: state_d = IDLE;
          endcase
          pend_d = PEND_NONE;
        end else begin
          dead_cnt_d = dead_cnt_q - DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = PEND_NONE;
      end
    endcase
    forward_d  = (state_d == RUN_FWD);
    backward_d = (state_d == RUN_BWD);
    busy_d     = (state_d != IDLE);
  end

  // State register: synchronous reset clears every flop, including mid-operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      level_q    <= 3'b000;
      press_q    <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      state_q    <= IDLE;
      pend_q     <= PEND_NONE;
      run_cnt_q  <= '0;
      dead_cnt_q <= '0;
      forward_q  <= 1'b0;
      backward_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      press_q    <= press_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q    <= state_d;
      pend_q     <= pend_d;
      run_cnt_q  <= run_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      forward_q  <= forward_d;
      backward_q <= backward_d;
      busy_q     <= busy_d;
    end
  end

  assign forward  = forward_q;
  assign backward = backward_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule

// File: tb/tb_drive_cmd_ctrl.sv
// tb_drive_cmd_ctrl: directed scenarios plus randomized button traffic,
// every cycle compared against a behavioural model of the command stage.
module tb_drive_cmd_ctrl;

  localparam int D  = 4;
  localparam int RC = 20;
  localparam int DC = 5;

  logic       clk = 1'b0;
  logic       reset, btn_fwd, btn_bwd, btn_stop;
  logic       forward, backward, busy;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  drive_cmd_ctrl #(.DEBOUNCE_CYCLES(D), .RUN_CYCLES(RC), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .btn_fwd(btn_fwd), .btn_bwd(btn_bwd),
    .btn_stop(btn_stop), .forward(forward), .backward(backward),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // raw sample history per button, [0] = newest edge
  bit       hist [3][D+2];
  bit [2:0] m_lvl;
  bit [2:0] m_ev;     // press flags detected at the previous edge
  int       m_state;  // 0 idle, 1 fwd, 2 bwd, 3 dead
  int       m_left;   // cycles left in the current timed state
  int       m_pend;   // 0 none, 1 fwd, 2 bwd

  task automatic model_step(input bit rst, input bit [2:0] raw);
    bit s, f, b, all_diff;
    bit [2:0] new_ev;
    if (rst) begin
      foreach (hist[i, k]) hist[i][k] = 1'b0;
      m_lvl = 3'b000; m_ev = 3'b000;
      m_state = 0; m_left = 0; m_pend = 0;
    end else begin
      s = m_ev[2];
      f = m_ev[0] && !m_ev[1] && !s;
      b = m_ev[1] && !m_ev[0] && !s;
      if (m_state == 0) begin
        if (f) begin m_state = 1; m_left = RC; end
        else if (b) begin m_state = 2; m_left = RC; end
      end else if (m_state == 1 || m_state == 2) begin
        if (s) begin m_state = 3; m_left = DC; m_pend = 0; end
        else if ((m_state == 1 && b) || (m_state == 2 && f)) begin
          m_pend = f ? 1 : 2; m_state = 3; m_left = DC;
        end else if (f || b) m_left = RC;
        else begin
          m_left--;
          if (m_left == 0) begin m_state = 3; m_left = DC; m_pend = 0; end
        end
      end else begin
        if (s) m_pend = 0;
        else if (f) m_pend = 1;
        else if (b) m_pend = 2;
        m_left--;
        if (m_left == 0) begin
          m_state = m_pend;
          m_left  = RC;
          m_pend  = 0;
        end
      end
      // debounce: a level flips once the synchronised input (raw two edges ago)
      // has disagreed with it for D consecutive edges
      for (int i = 0; i < 3; i++) begin
        for (int k = D + 1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = raw[i];
        all_diff = 1'b1;
        for (int k = 2; k <= D + 1; k++) if (hist[i][k] == m_lvl[i]) all_diff = 1'b0;
        new_ev[i] = 1'b0;
        if (all_diff) begin
          m_lvl[i]  = ~m_lvl[i];
          new_ev[i] = m_lvl[i];
        end
      end
      m_ev = new_ev;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // one clock: advance model with the inputs the DUT samples, then compare
  task automatic tick();
    @(posedge clk);
    model_step(reset, {btn_stop, btn_bwd, btn_fwd});
    #1;
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("forward", 32'(forward), 32'(m_state == 1));
    check_eq("backward", 32'(backward), 32'(m_state == 2));
    check_eq("busy", 32'(busy), 32'(m_state != 0));
    if (forward && backward) check_eq("exclusive", 32'(1), 32'(0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int rise, fall, fin, brise, bfall, seen, hold;

  initial begin
    reset = 1'b1; btn_fwd = 1'b0; btn_bwd = 1'b0; btn_stop = 1'b0;
    idle(2);
    check_eq("reset_state", 32'(state), 32'(0));
    check_eq("reset_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    idle(3);

    // held forward: rise at edge D+3, RC cycles high, DC cycles dead, then idle
    btn_fwd = 1'b1; rise = -1; fall = -1; fin = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (forward && rise < 0) rise = i;
      if (!forward && rise >= 0 && fall < 0) fall = i;
      if (!busy && fall >= 0 && fin < 0) fin = i;
    end
    check_eq("t1_rise_edge", 32'(rise), 32'(7));
    check_eq("t1_run_len", 32'(fall - rise), 32'(RC));
    check_eq("t1_dead_len", 32'(fin - fall), 32'(DC));
    btn_fwd = 1'b0; idle(10);

    // glitch shorter than debounce window
    btn_fwd = 1'b1; idle(3); btn_fwd = 1'b0; seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (forward || busy) seen = 1; end
    check_eq("t2_glitch", 32'(seen), 32'(0));

    // reversal from RUN_FWD via a backward press
    btn_fwd = 1'b1; idle(10);
    btn_fwd = 1'b0; btn_bwd = 1'b1; fall = -1; brise = -1; bfall = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!forward && fall < 0) fall = i;
      if (backward && brise < 0) brise = i;
      if (!backward && brise >= 0 && bfall < 0) bfall = i;
    end
    check_eq("t3_fwd_drop", 32'(fall), 32'(7));
    check_eq("t3_gap", 32'(brise - fall), 32'(DC));
    check_eq("t3_bwd_len", 32'(bfall - brise), 32'(RC));
    btn_bwd = 1'b0; idle(40);

    // simultaneous fwd+bwd, then fwd+bwd+stop, from IDLE
    btn_fwd = 1'b1; btn_bwd = 1'b1; seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (busy) seen = 1; end
    check_eq("t4_pair_ignored", 32'(seen), 32'(0));
    btn_fwd = 1'b0; btn_bwd = 1'b0; idle(10);
    btn_fwd = 1'b1; btn_bwd = 1'b1; btn_stop = 1'b1; idle(20);
    check_eq("t4_triple_idle", 32'(state), 32'(0));
    btn_fwd = 1'b0; btn_bwd = 1'b0; btn_stop = 1'b0; idle(10);

    // stop in RUN_BWD, forward press during the dead-time
    btn_bwd = 1'b1; idle(10);
    btn_bwd = 1'b0; btn_stop = 1'b1; idle(2);
    btn_fwd = 1'b1; idle(8);
    check_eq("t5_dead", 32'(state), 32'(3));
    idle(5);
    check_eq("t5_resume_fwd", 32'(forward), 32'(1));
    btn_fwd = 1'b0; btn_stop = 1'b0; idle(45);

    // reset mid-RUN_FWD with the button still held: seen as a fresh press
    btn_fwd = 1'b1; idle(12);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("t6_reset_fwd", 32'(forward), 32'(0));
    check_eq("t6_reset_state", 32'(state), 32'(0));
    rise = -1;
    for (int i = 1; i <= 15; i++) begin tick(); if (forward && rise < 0) rise = i; end
    check_eq("t6_rearm_edge", 32'(rise), 32'(7));
    btn_fwd = 1'b0; idle(40);

    // randomized button traffic with occasional resets
    for (int it = 0; it < 250; it++) begin
      reset    = ($urandom_range(0, 40) == 0);
      btn_fwd  = ($urandom_range(0, 3) == 0);
      btn_bwd  = ($urandom_range(0, 3) == 0);
      btn_stop = ($urandom_range(0, 6) == 0);
      hold = reset ? 1 : int'($urandom_range(1, 12));
      idle(hold);
      reset = 1'b0;
    end
    btn_fwd = 1'b0; btn_bwd = 1'b0; btn_stop = 1'b0;
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drive_cmd_ctrl.md
Name: drive_cmd_ctrl

Overview:
- Upstream command stage for the servo drive path; produces the `forward`/`backward` levels that the motor pulse generator consumes.
- Converts raw push-button inputs into clean, time-limited drive commands.
- Inputs are synchronised and debounced; each command runs for a fixed duration.
- A mandatory dead-time is inserted after every motion, including before any direction reversal, so the servo never sees an instant reversal.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz).
- RUN_CYCLES, 100000000: cycles a drive command stays asserted (1 s).
- DEAD_CYCLES, 5000000: cycles with both outputs low after any motion (50 ms).
- All counter widths are $clog2(param+1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_fwd  input  1  raw asynchronous forward button, active-high.
- btn_bwd  input  1  raw asynchronous backward button, active-high.
- btn_stop  input  1  raw asynchronous stop button, active-high.
- forward  output  1  drive-forward command to motor stage.
- backward  output  1  drive-backward command to motor stage.
- busy  output  1  high whenever state != IDLE.
- state  output  2  IDLE=0, RUN_FWD=1, RUN_BWD=2, DEAD=3.

Behaviour:
- Reset: one clock with reset high clears everything, mid-operation included.
  - Cleared: synchroniser flops, debounce counters and levels, run/dead counters, and the pending register.
  - Outputs: forward=0, backward=0, busy=0, state=IDLE.
  - A button held through reset is seen as a new press after reset releases.
- Sync: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - The counter increments while the synchronised value differs from the debounced level, and clears when they are equal.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Press event: one-cycle pulse when the debounced level goes 0->1; releases generate no event.
- Event priority within a cycle:
  - stop beats everything.
  - fwd and bwd in the same cycle with no stop are ignored.
- FSM:
  - IDLE:
    - fwd only -> RUN_FWD, run counter loaded.
    - bwd only -> RUN_BWD, run counter loaded.
    - stop -> stays IDLE.
  - RUN_FWD:
    - stop -> DEAD, pending=NONE.
    - bwd -> DEAD, pending=BWD.
    - fwd -> remain, run counter reloaded (extends run).
    - run count expiry (RUN_CYCLES cycles in state) -> DEAD, pending=NONE.
  - RUN_BWD: mirror of RUN_FWD.
  - DEAD:
    - Held for exactly DEAD_CYCLES cycles.
    - stop clears pending.
    - fwd/bwd overwrite pending; the dead counter is not restarted.
    - On expiry: pending FWD -> RUN_FWD, pending BWD -> RUN_BWD, NONE -> IDLE; pending is cleared on exit.
- Outputs:
  - forward = (state==RUN_FWD) and backward = (state==RUN_BWD), both registered.
  - forward and backward are never high simultaneously.
  - A direction change always shows at least DEAD_CYCLES cycles of both low.
- Latency:
  - forward/backward rises on rising edge DEBOUNCE_CYCLES+3, counting the first edge at which the raw button is high as edge 1.
  - The output then stays high for exactly RUN_CYCLES cycles, absent other events.
- Boundaries:
  - A glitch shorter than DEBOUNCE_CYCLES produces no event.
  - A held button produces exactly one event.
  - A reload in the final run cycle still extends the run by a full RUN_CYCLES.

Test Plan (DEBOUNCE_CYCLES=4, RUN_CYCLES=20, DEAD_CYCLES=5):
- btn_fwd held high from edge 1 -> forward=1 at edge 7, stays high 20 cycles, then state=DEAD for 5 cycles, then IDLE with busy=0.
- btn_fwd high for 3 cycles, then low -> no event; forward stays 0, state stays IDLE.
- In RUN_FWD, btn_bwd press -> forward drops immediately, both outputs 0 for exactly 5 cycles, then backward=1 for 20 cycles.
- btn_fwd and btn_bwd pressed in the same cycle from IDLE -> both outputs stay 0, state=IDLE; the same pair plus btn_stop -> state stays IDLE.
- In RUN_BWD, btn_stop press -> DEAD for 5 cycles, then IDLE; a btn_fwd press during DEAD, after the stop, -> RUN_FWD on DEAD expiry.
- reset pulsed 1 cycle mid-RUN_FWD with btn_fwd still held -> next cycle forward=0, state=IDLE; forward re-asserts 6 cycles after reset deasserts.
